// File: rtl/mac_stage.sv
// PE multiply-accumulate stage: per-row sub-word SIMD dot product, accumulated
// over a group of beats onto the incoming psum, one finished psum per row per group.
module mac_stage #(
    parameter int unsigned DWD     = 16,
    parameter int unsigned PSUMDWD = 32,
    parameter int unsigned PEROW   = 3,
    parameter int unsigned CNTW    = 4,
    parameter int unsigned FSCW    = 8,
    parameter int unsigned SSW     = 8,
    parameter int unsigned PPW     = 8,
    localparam int unsigned MODEW  = 3,
    localparam int unsigned PIPEW  = MODEW + CNTW + FSCW + SSW + PPW,
    localparam int unsigned ROWW   = 2 * DWD + PSUMDWD
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            FS_rdy,
    output logic                            FS_ack,
    input  logic [PIPEW-1:0]                i_pipe,
    input  logic [PEROW-1:0][ROWW-1:0]      i_data,
    output logic                            MS_rdy,
    input  logic                            MS_ack,
    output logic [PEROW-1:0][PSUMDWD-1:0]   o_data,
    output logic [SSW+PPW-1:0]              o_MSpipe_MS
);

    // i_pipe layout, MSB first: {mode, iNumT, fsctl, ssctl, ssppctl}
    localparam int unsigned PP_LSB   = 0;
    localparam int unsigned FSC_LSB  = PPW + SSW;
    localparam int unsigned NUMT_LSB = FSC_LSB + FSCW;
    localparam int unsigned MODE_LSB = NUMT_LSB + CNTW;
    localparam int unsigned CTLW     = SSW + PPW;

    logic [MODEW-1:0] mode_c;
    logic [CNTW-1:0]  numt_c;
    logic [CTLW-1:0]  ctl_c;
    logic             unused_fsctl;

    assign mode_c       = i_pipe[MODE_LSB +: MODEW];
    assign numt_c       = i_pipe[NUMT_LSB +: CNTW];
    assign ctl_c        = i_pipe[PP_LSB +: CTLW];
    assign unused_fsctl = ^i_pipe[FSC_LSB +: FSCW];

    // Signed lane products at twice the lane width, summed at psum width.
    function automatic logic signed [PSUMDWD-1:0] simd_dot(
        input logic [MODEW-1:0] mode,
        input logic [DWD-1:0]   a,
        input logic [DWD-1:0]   b
    );
        logic signed [PSUMDWD-1:0] s;
        logic        [DWD-1:0]     x;
        logic signed [3:0]         p2;
        logic signed [7:0]         p4;
        logic signed [15:0]        p8;
        logic signed [2*DWD-1:0]   p16;
        s = '0;
        case (mode)
            3'd0: begin
                x = ~(a ^ b);
                for (int i = 0; i < int'(DWD); i++) s = s + PSUMDWD'(x[i]);
                s = (s <<< 1) - PSUMDWD'(DWD);
            end
            3'd1: for (int k = 0; k < int'(DWD / 2); k++) begin
                p2 = signed'({{2{a[2*k+1]}}, a[2*k +: 2]}) * signed'({{2{b[2*k+1]}}, b[2*k +: 2]});
                s  = s + PSUMDWD'(p2);
            end
            3'd2: for (int k = 0; k < int'(DWD / 4); k++) begin
                p4 = signed'({{4{a[4*k+3]}}, a[4*k +: 4]}) * signed'({{4{b[4*k+3]}}, b[4*k +: 4]});
                s  = s + PSUMDWD'(p4);
            end
            3'd3: for (int k = 0; k < int'(DWD / 8); k++) begin
                p8 = signed'({{8{a[8*k+7]}}, a[8*k +: 8]}) * signed'({{8{b[8*k+7]}}, b[8*k +: 8]});
                s  = s + PSUMDWD'(p8);
            end
            3'd4: begin
                p16 = signed'({{DWD{a[DWD-1]}}, a}) * signed'({{DWD{b[DWD-1]}}, b});
                s   = PSUMDWD'(p16);
            end
            default: s = '0;
        endcase
        return s;
    endfunction

    // Group tracking on the input side
    logic            first_q;
    logic [CNTW-1:0] numt_q;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] numt_eff_c;
    logic [CNTW-1:0] cnt_eff_c;
    logic            last_c;

    // S1 register
    logic                          s1_v;
    logic                          s1_first;
    logic                          s1_last;
    logic [CTLW-1:0]               s1_ctl;
    logic [PEROW-1:0][PSUMDWD-1:0] s1_dot;
    logic [PEROW-1:0][PSUMDWD-1:0] s1_psum;

    logic [PEROW-1:0][PSUMDWD-1:0] dot_c;
    logic [PEROW-1:0][PSUMDWD-1:0] acc;
    logic [PEROW-1:0][PSUMDWD-1:0] acc_next_c;

    logic s2_free_c;
    logic s1_move_c;
    logic fs_xfer_c;

    assign s2_free_c = !MS_rdy || MS_ack;
    assign s1_move_c = s1_v && (!s1_last || s2_free_c);
    assign FS_ack    = !s1_v || s1_move_c;
    assign fs_xfer_c = FS_rdy && FS_ack;

    always_comb begin
        numt_eff_c = first_q ? numt_c : numt_q;
        cnt_eff_c  = first_q ? '0 : cnt_q;
        last_c     = (cnt_eff_c == numt_eff_c);
    end

    always_comb begin
        dot_c      = '0;
        acc_next_c = '0;
        for (int r = 0; r < int'(PEROW); r++) begin
            dot_c[r]      = simd_dot(mode_c, i_data[r][PSUMDWD+DWD +: DWD], i_data[r][PSUMDWD +: DWD]);
            acc_next_c[r] = (s1_first ? s1_psum[r] : acc[r]) + s1_dot[r];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            first_q <= 1'b1;
            numt_q  <= '0;
            cnt_q   <= '0;
        end else if (fs_xfer_c) begin
            numt_q  <= numt_eff_c;
            first_q <= last_c;
            cnt_q   <= last_c ? '0 : cnt_eff_c + CNTW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_v     <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_ctl   <= '0;
            s1_dot   <= '0;
            s1_psum  <= '0;
        end else if (FS_ack) begin
            s1_v <= FS_rdy;
            if (FS_rdy) begin
                s1_first <= first_q;
                s1_last  <= last_c;
                s1_ctl   <= ctl_c;
                s1_dot   <= dot_c;
                for (int r = 0; r < int'(PEROW); r++) s1_psum[r] <= i_data[r][PSUMDWD-1:0];
            end
        end
    end

    // Accumulator and output register; a new last beat wins over a same-cycle ack
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc         <= '0;
            o_data      <= '0;
            o_MSpipe_MS <= '0;
            MS_rdy      <= 1'b0;
        end else begin
            if (s1_move_c) acc <= acc_next_c;
            if (s1_move_c && s1_last) begin
                o_data      <= acc_next_c;
                o_MSpipe_MS <= s1_ctl;
                MS_rdy      <= 1'b1;
            end else if (MS_ack) begin
                MS_rdy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_stage.sv
// Directed bench for mac_stage: reference dot-product model feeding a scoreboard
// of expected group results, popped whenever the stage hands a result downstream.
module tb_mac_stage;

    localparam int unsigned PIPEW = 31;

    logic                 clk = 1'b0;
    logic                 i_rst;
    logic                 FS_rdy;
    logic                 FS_ack;
    logic [PIPEW-1:0]     i_pipe;
    logic [2:0][63:0]     i_data;
    logic                 MS_rdy;
    logic                 MS_ack;
    logic [2:0][31:0]     o_data;
    logic [15:0]          o_MSpipe_MS;

    always #5 clk = ~clk;

    mac_stage dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .FS_rdy      (FS_rdy),
        .FS_ack      (FS_ack),
        .i_pipe      (i_pipe),
        .i_data      (i_data),
        .MS_rdy      (MS_rdy),
        .MS_ack      (MS_ack),
        .o_data      (o_data),
        .o_MSpipe_MS (o_MSpipe_MS)
    );

    typedef struct packed {
        logic [2:0][31:0] data;
        logic [15:0]      ctl;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;
    int n_stall  = 0;

    logic             m_first = 1'b1;
    logic [3:0]       m_numt  = '0;
    logic [3:0]       m_cnt   = '0;
    logic [2:0][31:0] m_acc   = '0;

    logic         prev_hold = 1'b0;
    logic [111:0] prev_out  = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
        n_checks++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    endtask

    function automatic logic [31:0] ref_dot(input logic [2:0] mode, input logic [15:0] a, input logic [15:0] b);
        int s, l, va, vb;
        if (mode == 3'd0) return 32'(2 * $countones(~(a ^ b)) - 16);
        if (mode > 3'd4) return 32'd0;
        l = 1 << mode;
        s = 0;
        for (int k = 0; k < 16 / l; k++) begin
            va = int'(a >> (k * l)) & ((1 << l) - 1);
            vb = int'(b >> (k * l)) & ((1 << l) - 1);
            if (va >= (1 << (l - 1))) va -= (1 << l);
            if (vb >= (1 << (l - 1))) vb -= (1 << l);
            s += va * vb;
        end
        return 32'(s);
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is taken
    task automatic send(input logic [2:0] mode, input logic [3:0] numt,
                        input logic [2:0][15:0] iv, input logic [2:0][15:0] wv,
                        input logic [2:0][31:0] ps);
        logic [7:0] ss, pp;
        bit ok;
        ss = 8'($urandom);
        pp = 8'($urandom);
        FS_rdy = 1'b1;
        i_pipe = {mode, numt, 8'($urandom), ss, pp};
        for (int r = 0; r < 3; r++) i_data[r] = {iv[r], wv[r], ps[r]};
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (FS_ack) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("fs_ack_timeout", 128'(FS_ack), 128'd1);
        else begin
            if (m_first) begin
                m_numt = numt;
                m_cnt  = '0;
                for (int r = 0; r < 3; r++) m_acc[r] = ps[r] + ref_dot(mode, iv[r], wv[r]);
            end else begin
                for (int r = 0; r < 3; r++) m_acc[r] = m_acc[r] + ref_dot(mode, iv[r], wv[r]);
            end
            if (m_cnt == m_numt) begin
                sb.push_back('{data: m_acc, ctl: {ss, pp}});
                m_first = 1'b1;
                m_cnt   = '0;
            end else begin
                m_first = 1'b0;
                m_cnt   = m_cnt + 4'd1;
            end
        end
        @(posedge clk);
        #1;
        FS_rdy = 1'b0;
    endtask

    task automatic wait_rdy();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (MS_rdy) break;
        end
        check("ms_rdy_seen", 128'(MS_rdy), 128'd1);
    endtask

    // Output monitor: scoreboard pop on handoff, hold stability while stalled
    always @(negedge clk) begin
        if (i_rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && MS_rdy) check("hold_stable", 128'({o_data, o_MSpipe_MS}), 128'(prev_out));
            if (MS_rdy && MS_ack) begin
                n_out++;
                n_checks++;
                assert (sb.size() > 0) n_pass++;
                else $error("FAIL spurious_output observed=%0h expected=none", o_data);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check("sb_data", 128'(o_data), 128'(mon_e.data));
                    check("sb_ctl", 128'(o_MSpipe_MS), 128'(mon_e.ctl));
                end
            end
            if (FS_rdy && !FS_ack) n_stall++;
            prev_hold = MS_rdy && !MS_ack;
            prev_out  = {o_data, o_MSpipe_MS};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0][15:0] iv, wv, ones;
        logic [2:0][31:0] ps;
        int n0, st0;
        logic [2:0] md;
        logic [3:0] nt;

        ones   = {3{16'h0001}};
        i_rst  = 1'b1;
        FS_rdy = 1'b0;
        MS_ack = 1'b1;
        i_pipe = '0;
        i_data = '0;
        repeat (3) @(posedge clk);
        #1;
        i_rst = 1'b0;
        @(negedge clk);
        check("rst_ms_rdy", 128'(MS_rdy), 128'd0);
        check("rst_fs_ack", 128'(FS_ack), 128'd1);
        check("rst_o_data", 128'(o_data), 128'd0);
        check("rst_o_pipe", 128'(o_MSpipe_MS), 128'd0);
        sync();

        // INT8 single beat plus latency
        iv = {16'h1234, 16'h8000, 16'h02FD};
        wv = {16'h5678, 16'h8000, 16'h0304};
        ps = {32'd1, 32'hFFFF_FFFF, 32'd100};
        send(3'd3, 4'd0, iv, wv, ps);
        @(negedge clk);
        check("lat_t1_ms_rdy", 128'(MS_rdy), 128'd0);
        @(negedge clk);
        check("lat_t2_ms_rdy", 128'(MS_rdy), 128'd1);
        check("int8_row0", 128'(o_data[0]), 128'd94);
        sync();

        // XNOR
        iv = {16'h0F0F, 16'hFFFF, 16'hFFFF};
        wv = {16'h00FF, 16'h0000, 16'hFFFF};
        ps = '0;
        send(3'd0, 4'd0, iv, wv, ps);
        wait_rdy();
        check("xnor_all_match", 128'(o_data[0]), 128'd16);
        check("xnor_all_diff", 128'(o_data[1]), 128'h0000_0000_0000_0000_0000_0000_FFFF_FFF0);
        sync();

        // INT4 four-beat group, later psums ignored
        n0 = n_out;
        iv = {3{16'h1111}};
        send(3'd2, 4'd3, iv, iv, {3{32'd5}});
        for (int b = 0; b < 3; b++) send(3'd2, 4'd0, iv, iv, {3{32'd999}});
        wait_rdy();
        check("int4_group", 128'(o_data[0]), 128'd21);
        repeat (4) @(negedge clk);
        check("int4_one_pulse", 128'(n_out - n0), 128'd1);
        sync();

        // INT16 wrap
        send(3'd4, 4'd0, ones, ones, {32'd0, 32'd0, 32'h7FFF_FFFF});
        wait_rdy();
        check("int16_wrap", 128'(o_data[0]), 128'h8000_0000);
        sync();

        // Mixed modes and group lengths, back to back
        for (int b = 0; b < 14 || !m_first; b++) begin
            md = 3'($urandom_range(0, 7));
            nt = 4'($urandom_range(0, 2));
            for (int r = 0; r < 3; r++) begin
                iv[r] = 16'($urandom);
                wv[r] = 16'($urandom);
                ps[r] = $urandom;
            end
            send(md, nt, iv, wv, ps);
        end
        repeat (4) @(negedge clk);
        sync();

        // Backpressure with single-beat groups
        st0 = n_stall;
        MS_ack = 1'b0;
        fork
            begin
                for (int b = 0; b < 4; b++) begin
                    for (int r = 0; r < 3; r++) begin
                        iv[r] = 16'($urandom);
                        wv[r] = 16'($urandom);
                        ps[r] = $urandom;
                    end
                    send(3'd3, 4'd0, iv, wv, ps);
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                MS_ack = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        check("fs_ack_dropped", 128'(n_stall > st0), 128'd1);
        check("bp_drained", 128'(sb.size()), 128'd0);
        sync();

        // Reset in the middle of a group
        send(3'd4, 4'd3, ones, ones, {3{32'd7}});
        send(3'd4, 4'd3, ones, ones, {3{32'd7}});
        i_rst  = 1'b1;
        FS_rdy = 1'b1;
        i_pipe = {3'd4, 4'd3, 24'h0};
        @(posedge clk);
        #1;
        i_rst   = 1'b0;
        FS_rdy  = 1'b0;
        m_first = 1'b1;
        m_cnt   = '0;
        @(negedge clk);
        check("midrst_ms_rdy", 128'(MS_rdy), 128'd0);
        check("midrst_fs_ack", 128'(FS_ack), 128'd1);
        sync();
        send(3'd4, 4'd0, ones, ones, {3{32'd7}});
        wait_rdy();
        check("post_rst_group", 128'(o_data[0]), 128'd8);

        repeat (5) @(negedge clk);
        check("sb_empty", 128'(sb.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
